// File: rtl/prefix_sub_pipe.sv
// Pipelined add/subtract/compare unit built on a Kogge-Stone prefix tree.
// Three register stages: operand preconditioning (S0), the low prefix
// levels (S1), and the high prefix levels plus sum, mask and flags (S2,
// which drives the out_* registers). A single global advance signal
// moves every stage at once; bubbles travel as empty slots.
module prefix_sub_pipe #(
  parameter int W         = 64,
  parameter int PFX_SPLIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_op,
  input  logic [1:0]   in_wsel,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic         out_carry,
  output logic         out_zero,
  output logic         out_neg,
  output logic         out_ovf,
  output logic         out_lt,
  output logic         out_ltu
);

  localparam int LEVELS = 6;

  // One Kogge-Stone level: combine each (g,p) with the pair 'span' bits below.
  // Returns {g_next, p_next}.
  function automatic logic [2*W-1:0] ks_level(input logic [W-1:0] g,
                                              input logic [W-1:0] p,
                                              input int span);
    logic [W-1:0] gn;
    logic [W-1:0] pn;
    for (int i = 0; i < W; i++) begin
      if (i >= span) begin
        gn[i] = g[i] | (p[i] & g[i-span]);
        pn[i] = p[i] & p[i-span];
      end else begin
        gn[i] = g[i];
        pn[i] = p[i];
      end
    end
    return {gn, pn};
  endfunction

  logic         advance_s;
  logic [W-1:0] b_eff_s;
  logic [W-1:0] g_in_s;
  logic [W-1:0] p_in_s;

  // S0 state
  logic         v0_r;
  logic         cin0_r;
  logic [1:0]   wsel0_r;
  logic [3:0]   asgn0_r;
  logic [W-1:0] g0_r;
  logic [W-1:0] p0_r;

  // S1 state
  logic         v1_r;
  logic         cin1_r;
  logic [1:0]   wsel1_r;
  logic [3:0]   asgn1_r;
  logic [W-1:0] p1_r;
  logic [W-1:0] gg1_r;
  logic [W-1:0] pp1_r;

  logic [W-1:0] gg_s1;
  logic [W-1:0] pp_s1;
  logic [W-1:0] gg_s2;
  logic [W-1:0] pp_s2;
  logic [W-1:0] sum_s;
  logic [W-1:0] mask_s;
  logic [5:0]   msb_s;
  logic         a_msb_s;
  logic [W-1:0] res_s;
  logic         carry_s;
  logic         neg_s;
  logic         ovf_s;

  assign advance_s = out_ready | ~out_valid;
  assign in_ready  = advance_s;

  // Operand conditioning: invert B for subtract, fold carry-in into bit 0 generate.
  always_comb begin
    b_eff_s = in_b;
    if (in_op) begin
      b_eff_s = ~in_b;
    end else begin
      b_eff_s = in_b;
    end
    g_in_s    = in_a & b_eff_s;
    p_in_s    = in_a ^ b_eff_s;
    g_in_s[0] = (in_a[0] & b_eff_s[0]) | (p_in_s[0] & in_op);
  end

  // S0 register: per-bit generate/propagate plus per-beat op, width and A sign bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_r    <= 1'b0;
      cin0_r  <= 1'b0;
      wsel0_r <= 2'd0;
      asgn0_r <= 4'd0;
      g0_r    <= '0;
      p0_r    <= '0;
    end else if (advance_s) begin
      v0_r <= in_valid;
      if (in_valid) begin
        cin0_r  <= in_op;
        wsel0_r <= in_wsel;
        asgn0_r <= {in_a[63], in_a[31], in_a[15], in_a[7]};
        g0_r    <= g_in_s;
        p0_r    <= p_in_s;
      end
    end
  end

  // Low prefix levels (spans below 2^PFX_SPLIT).
  always_comb begin
    gg_s1 = g0_r;
    pp_s1 = p0_r;
    for (int l = 0; l < LEVELS; l++) begin
      if (l < PFX_SPLIT) begin
        {gg_s1, pp_s1} = ks_level(gg_s1, pp_s1, 1 << l);
      end else begin
        {gg_s1, pp_s1} = {gg_s1, pp_s1};
      end
    end
  end

  // S1 register: partial prefix tree, original propagate kept for the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r    <= 1'b0;
      cin1_r  <= 1'b0;
      wsel1_r <= 2'd0;
      asgn1_r <= 4'd0;
      p1_r    <= '0;
      gg1_r   <= '0;
      pp1_r   <= '0;
    end else if (advance_s) begin
      v1_r <= v0_r;
      if (v0_r) begin
        cin1_r  <= cin0_r;
        wsel1_r <= wsel0_r;
        asgn1_r <= asgn0_r;
        p1_r    <= p0_r;
        gg1_r   <= gg_s1;
        pp1_r   <= pp_s1;
      end
    end
  end

  // High prefix levels, sum, width mask and flags; gg_s2[i] is the carry out of bit i.
  always_comb begin
    gg_s2 = gg1_r;
    pp_s2 = pp1_r;
    for (int l = 0; l < LEVELS; l++) begin
      if (l >= PFX_SPLIT) begin
        {gg_s2, pp_s2} = ks_level(gg_s2, pp_s2, 1 << l);
      end else begin
        {gg_s2, pp_s2} = {gg_s2, pp_s2};
      end
    end
    sum_s = p1_r ^ {gg_s2[W-2:0], cin1_r};
    case (wsel1_r)
      2'd0: begin mask_s = 64'h0000_0000_0000_00FF; msb_s = 6'd7;  a_msb_s = asgn1_r[0]; end
      2'd1: begin mask_s = 64'h0000_0000_0000_FFFF; msb_s = 6'd15; a_msb_s = asgn1_r[1]; end
      2'd2: begin mask_s = 64'h0000_0000_FFFF_FFFF; msb_s = 6'd31; a_msb_s = asgn1_r[2]; end
      2'd3: begin mask_s = 64'hFFFF_FFFF_FFFF_FFFF; msb_s = 6'd63; a_msb_s = asgn1_r[3]; end
      default: begin mask_s = 64'hFFFF_FFFF_FFFF_FFFF; msb_s = 6'd63; a_msb_s = asgn1_r[3]; end
    endcase
    res_s   = sum_s & mask_s;
    carry_s = gg_s2[msb_s];
    neg_s   = sum_s[msb_s];
    // Same-sign operands (propagate 0 at the msb) whose sum flips sign.
    ovf_s   = ~p1_r[msb_s] & (sum_s[msb_s] ^ a_msb_s);
  end

  // S2 / output register: holds bit-exactly while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
      out_ovf   <= 1'b0;
      out_lt    <= 1'b0;
      out_ltu   <= 1'b0;
    end else if (advance_s) begin
      out_valid <= v1_r;
      if (v1_r) begin
        out_res   <= res_s;
        out_carry <= carry_s;
        out_zero  <= (res_s == '0);
        out_neg   <= neg_s;
        out_ovf   <= ovf_s;
        out_lt    <= neg_s ^ ovf_s;
        out_ltu   <= ~carry_s;
      end
    end
  end

endmodule

// File: tb/tb_prefix_sub_pipe.sv
// Directed self-checking bench for prefix_sub_pipe.
module tb_prefix_sub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_op = 1'b0;
  logic [1:0]  in_wsel = 2'd3;
  logic [63:0] in_a = 64'd0;
  logic [63:0] in_b = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_res;
  logic        out_carry;
  logic        out_zero;
  logic        out_neg;
  logic        out_ovf;
  logic        out_lt;
  logic        out_ltu;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  prefix_sub_pipe #(.W(64), .PFX_SPLIT(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_wsel(in_wsel),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_carry(out_carry), .out_zero(out_zero), .out_neg(out_neg),
    .out_ovf(out_ovf), .out_lt(out_lt), .out_ltu(out_ltu)
  );

  always #5 clk = ~clk;

  // flags packed as {carry, zero, neg, ovf, lt, ltu}
  function automatic logic [5:0] flags();
    return {out_carry, out_zero, out_neg, out_ovf, out_lt, out_ltu};
  endfunction

  // Drive one beat into an empty pipe and count cycles until out_valid (bounded).
  task automatic run_single(input logic op, input logic [1:0] wsel,
                            input logic [63:0] a, input logic [63:0] b,
                            output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_wsel = wsel; in_a = a; in_b = b;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Consume the currently presented result.
  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if ({out_res, flags()} !== 70'd0) $display("FAIL reset_outputs: got res=%h flags=%b want 0", out_res, flags());
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_sub64();
    int lat;
    run_single(1'b1, 2'd3, 64'd5, 64'd7, lat);
    chk_cnt++;
    if (lat !== 3) $display("FAIL sub64_latency: got %0d want 3", lat);
    else pass_cnt++;
    chk_cnt++;
    if (out_res !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL sub64_res: got %h want fffffffffffffffe", out_res);
    else pass_cnt++;
    chk_cnt++;
    if (flags() !== 6'b001011) $display("FAIL sub64_flags: got %b want 001011", flags());
    else pass_cnt++;
    drain();
  endtask

  task automatic test_add8_ovf();
    int lat;
    run_single(1'b0, 2'd0, 64'hABAB_ABAB_ABAB_AB7F, 64'h1, lat);
    chk_cnt++;
    if (out_res !== 64'h80) $display("FAIL add8_res: got %h want 80", out_res);
    else pass_cnt++;
    chk_cnt++;
    if (flags() !== 6'b001101) $display("FAIL add8_flags: got %b want 001101", flags());
    else pass_cnt++;
    drain();
  endtask

  task automatic test_sub32_ovf();
    int lat;
    run_single(1'b1, 2'd2, 64'h8000_0000, 64'h1, lat);
    chk_cnt++;
    if (out_res !== 64'h7FFF_FFFF) $display("FAIL sub32_res: got %h want 7fffffff", out_res);
    else pass_cnt++;
    chk_cnt++;
    if (flags() !== 6'b100110) $display("FAIL sub32_flags: got %b want 100110", flags());
    else pass_cnt++;
    drain();
  endtask

  task automatic test_sub16_zero();
    int lat;
    run_single(1'b1, 2'd1, 64'h1234, 64'h1234, lat);
    chk_cnt++;
    if (out_res !== 64'h0) $display("FAIL sub16_res: got %h want 0", out_res);
    else pass_cnt++;
    chk_cnt++;
    if (flags() !== 6'b110000) $display("FAIL sub16_flags: got %b want 110000", flags());
    else pass_cnt++;
    drain();
  endtask

  task automatic test_back_to_back();
    logic        ops [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  ws  [5] = '{2'd3, 2'd0, 2'd1, 2'd3, 2'd2};
    logic [63:0] as  [5] = '{64'd1, 64'h10, 64'hFFFF, 64'd100, 64'h1_0000_0005};
    logic [63:0] bs  [5] = '{64'd0, 64'h20, 64'h1, 64'd1, 64'h3};
    logic [63:0] exp [5] = '{64'd1, 64'hF0, 64'h0, 64'd99, 64'h8};
    int sent = 0;
    int got = 0;
    int stall_left = 4;
    int cyc = 0;
    logic stalling = 1'b0;
    logic [63:0] held;
    held = 64'd0;
    while (got < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      in_valid = (sent < 5);
      if (sent < 5) begin
        in_op = ops[sent]; in_wsel = ws[sent]; in_a = as[sent]; in_b = bs[sent];
      end
      #1;
      if (out_valid && !out_ready) begin
        chk_cnt++;
        if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready);
        else pass_cnt++;
        if (stalling) begin
          chk_cnt++;
          if (out_res !== held) $display("FAIL stall_hold: got %h want %h", out_res, held);
          else pass_cnt++;
        end else begin
          held = out_res;
        end
        stalling = 1'b1;
      end else begin
        stalling = 1'b0;
      end
      if (out_valid && out_ready) begin
        chk_cnt++;
        if (out_res !== exp[got]) $display("FAIL stream_res[%0d]: got %h want %h", got, out_res, exp[got]);
        else pass_cnt++;
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    chk_cnt++;
    if (got !== 5) $display("FAIL stream_count: got %0d want 5", got);
    else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL stream_no_dup: got out_valid=%b want 0", out_valid);
    else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = 1'b0; in_wsel = 2'd3;
      in_a = 64'd1000 + 64'(i); in_b = 64'd1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0 || out_res !== 64'd0) $display("FAIL midreset_clear: got valid=%b res=%h want 0/0", out_valid, out_res);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL midreset_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    run_single(1'b1, 2'd3, 64'd9, 64'd4, lat);
    chk_cnt++;
    if (lat !== 3) $display("FAIL midreset_latency: got %0d want 3", lat);
    else pass_cnt++;
    chk_cnt++;
    if (out_res !== 64'd5 || flags() !== 6'b100000) $display("FAIL midreset_res: got res=%h flags=%b want 5/100000", out_res, flags());
    else pass_cnt++;
    drain();
  endtask

  initial begin
    test_reset();
    test_sub64();
    test_add8_ovf();
    test_sub32_ovf();
    test_sub16_zero();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
